// File: rtl/multicycle_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl_pkg
//  Purpose  : Shared encodings for the multicycle controller: FSM states,
//             instruction opcodes, ALU functions, PC mux selects and the
//             datapath mux codes driven by the controller.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package multicycle_ctrl_pkg;

  // FSM state encodings; also visible on the debug "state" port.
  typedef enum logic [3:0] {
    S_RESET     = 4'd0,
    S_IF        = 4'd1,
    S_ID        = 4'd3,
    S_LR_ADDR   = 4'd4,
    S_SR_ADDR   = 4'd5,
    S_EXEC      = 4'd6,
    S_BRANCH    = 4'd7,
    S_MOVE      = 4'd8,
    S_ADDI      = 4'd9,
    S_JUMP      = 4'd10,
    S_MEM_READ  = 4'd11,
    S_MEM_WB    = 4'd12,
    S_MEM_STORE = 4'd13,
    S_ALU_WB    = 4'd14,
    S_ERROR     = 4'd15
  } state_e;

  // Instruction opcodes (instruction MSBs). 4'hD..4'hF are undefined.
  localparam logic [3:0] INSTR_NOP  = 4'h0;
  localparam logic [3:0] INSTR_ADD  = 4'h1;
  localparam logic [3:0] INSTR_SUB  = 4'h2;
  localparam logic [3:0] INSTR_AND  = 4'h3;
  localparam logic [3:0] INSTR_OR   = 4'h4;
  localparam logic [3:0] INSTR_LR   = 4'h5;
  localparam logic [3:0] INSTR_SR   = 4'h6;
  localparam logic [3:0] INSTR_BNEQ = 4'h7;
  localparam logic [3:0] INSTR_BEQ  = 4'h8;
  localparam logic [3:0] INSTR_MOV  = 4'h9;
  localparam logic [3:0] INSTR_LI   = 4'hA;
  localparam logic [3:0] INSTR_ADDI = 4'hB;
  localparam logic [3:0] INSTR_JMP  = 4'hC;

  // ALU functions.
  localparam logic [2:0] ALU_OP_ADD    = 3'd0;
  localparam logic [2:0] ALU_OP_SUB    = 3'd1;
  localparam logic [2:0] ALU_OP_AND    = 3'd2;
  localparam logic [2:0] ALU_OP_OR     = 3'd3;
  localparam logic [2:0] ALU_OP_PASS_A = 3'd4;

  // PC mux selects.
  localparam logic [1:0] PC_SELECT_RESET   = 2'd0;
  localparam logic [1:0] PC_SELECT_ALU     = 2'd1;
  localparam logic [1:0] PC_SELECT_ALU_BUF = 2'd2;

  // ALU operand selects.
  localparam logic       ALU_SRC_A_PC        = 1'b0;
  localparam logic       ALU_SRC_A_REG       = 1'b1;
  localparam logic [1:0] ALU_SRC_B_REG       = 2'd0;
  localparam logic [1:0] ALU_SRC_B_TWO       = 2'd1;
  localparam logic [1:0] ALU_SRC_B_IMM_BYTES = 2'd2;
  localparam logic [1:0] ALU_SRC_B_IMM_WORD  = 2'd3;

  // Register file write-back source.
  localparam logic MEM_TO_REG_ALU_OUT = 1'b0;
  localparam logic MEM_TO_REG_MEMORY  = 1'b1;

  // States that wait on mem_ready and are guarded by the wait timer.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_IF) || (s == S_MEM_READ) || (s == S_MEM_STORE);
  endfunction

endpackage : multicycle_ctrl_pkg
`default_nettype wire

// File: rtl/multicycle_ctrl_mem_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : mem_wait_timer
//  Purpose  : Counts consecutive cycles spent waiting on memory and flags a
//             timeout on the last allowed wait cycle.
//  Ports    : clk, reset    - clock, synchronous active-high reset
//             count_en_i    - high on each cycle spent waiting (mem_ready low)
//             timeout_o     - this wait cycle is the last one allowed
//  Revision : 1.0 - initial release
// ============================================================================
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic count_en_i,
  output logic timeout_o
);

  localparam logic [7:0] LAST_COUNT = 8'(MEM_TIMEOUT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  // Any non-waiting cycle (entering a wait state, or mem_ready seen) clears
  // the count, so each wait episode starts from zero.
  always_comb begin
    count_d = 8'd0;
    if (count_en_i) count_d = count_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= 8'd0;
    else       count_q <= count_d;
  end

  // Gated by count_en_i so a completing access (mem_ready high) never times out.
  assign timeout_o = count_en_i && (count_q == LAST_COUNT);

endmodule : mem_wait_timer
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : multicycle_ctrl
//  Purpose  : Multicycle CPU control FSM: fetch, decode, execute, memory and
//             write-back sequencing with a memory-wait timeout to ERROR.
//  Ports    : clk, reset        - clock, synchronous active-high reset
//             instruction       - instruction register (opcode in MSBs)
//             zero, mem_ready   - ALU zero flag, memory completion
//             *_enable, mem_*   - datapath strobes and selects
//             alu_src_a/b, alu_op, pc_source - datapath mux/function codes
//             error             - sticky fault flag
//             state             - current state encoding (debug)
//  Revision : 1.0 - initial release
// ============================================================================
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 16,
  parameter int WIDTH_OPCODE      = 4,
  parameter int ALU_OP_NUM_BITS   = 3,
  parameter int MEM_TIMEOUT       = 15
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [INSTRUCTION_WIDTH-1:0] instruction,
  input  logic                         zero,
  input  logic                         mem_ready,
  output logic                         ireg_write_enable,
  output logic                         regfile_write_enable,
  output logic                         pc_write_enable,
  output logic                         mem_read,
  output logic                         mem_select,
  output logic                         mem_to_reg,
  output logic                         alu_src_a,
  output logic [1:0]                   alu_src_b,
  output logic [ALU_OP_NUM_BITS-1:0]   alu_op,
  output logic [1:0]                   pc_source,
  output logic                         error,
  output logic [3:0]                   state
);

  state_e                  state_q, state_d;
  logic [WIDTH_OPCODE-1:0] op_q, op_d;
  logic [WIDTH_OPCODE-1:0] opcode_w;
  logic [3:0]              op_cur_w;
  logic [3:0]              op_held_w;
  logic [2:0]              alu_op_w;
  logic                    wait_en_w;
  logic                    timeout_w;
  logic                    unused_instr_bits;

  assign opcode_w          = instruction[INSTRUCTION_WIDTH-1 -: WIDTH_OPCODE];
  assign op_cur_w          = 4'(opcode_w);
  assign op_held_w         = 4'(op_q);
  assign unused_instr_bits = ^instruction[INSTRUCTION_WIDTH-WIDTH_OPCODE-1:0];

  // Only wait states see mem_ready; elsewhere it has no effect.
  assign wait_en_w = is_wait_state(state_q) && !mem_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk        (clk),
    .reset      (reset),
    .count_en_i (wait_en_w),
    .timeout_o  (timeout_w)
  );

  // Opcode is captured in decode so later states ignore instruction changes.
  assign op_d = (state_q == S_ID) ? opcode_w : op_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_RESET;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    ireg_write_enable    = 1'b0;
    regfile_write_enable = 1'b0;
    pc_write_enable      = 1'b0;
    mem_read             = 1'b0;
    mem_select           = 1'b0;
    mem_to_reg           = MEM_TO_REG_ALU_OUT;
    alu_src_a            = ALU_SRC_A_PC;
    alu_src_b            = ALU_SRC_B_REG;
    alu_op_w             = ALU_OP_ADD;
    pc_source            = PC_SELECT_RESET;
    error                = 1'b0;

    case (state_q)
      S_RESET: begin
        pc_write_enable = 1'b1;
        mem_read        = 1'b1;
        state_d         = S_IF;
      end
      S_IF: begin
        mem_read  = 1'b1;
        alu_src_b = ALU_SRC_B_TWO;
        pc_source = PC_SELECT_ALU;
        if (mem_ready) begin
          pc_write_enable   = 1'b1;
          ireg_write_enable = 1'b1;
          state_d           = S_ID;
        end else if (timeout_w) begin
          state_d = S_ERROR;
        end
      end
      S_ID: begin
        // PC + imm word is computed here and held in the ALU buffer as the
        // branch/jump target.
        alu_src_a = ALU_SRC_A_PC;
        alu_src_b = ALU_SRC_B_IMM_WORD;
        case (op_cur_w)
          INSTR_NOP:                            state_d = S_IF;
          INSTR_ADD, INSTR_SUB,
          INSTR_AND, INSTR_OR:                  state_d = S_EXEC;
          INSTR_LR:                             state_d = S_LR_ADDR;
          INSTR_SR:                             state_d = S_SR_ADDR;
          INSTR_BNEQ, INSTR_BEQ:                state_d = S_BRANCH;
          INSTR_MOV:                            state_d = S_MOVE;
          INSTR_LI, INSTR_ADDI:                 state_d = S_ADDI;
          INSTR_JMP:                            state_d = S_JUMP;
          default:                              state_d = S_ERROR;
        endcase
      end
      S_EXEC: begin
        alu_src_a = ALU_SRC_A_REG;
        alu_src_b = ALU_SRC_B_REG;
        case (op_held_w)
          INSTR_SUB: alu_op_w = ALU_OP_SUB;
          INSTR_AND: alu_op_w = ALU_OP_AND;
          INSTR_OR:  alu_op_w = ALU_OP_OR;
          default:   alu_op_w = ALU_OP_ADD;
        endcase
        state_d = S_ALU_WB;
      end
      S_ADDI: begin
        alu_src_a = ALU_SRC_A_REG;
        alu_src_b = ALU_SRC_B_IMM_BYTES;
        state_d   = S_ALU_WB;
      end
      S_MOVE: begin
        alu_src_a = ALU_SRC_A_REG;
        alu_src_b = ALU_SRC_B_REG;
        alu_op_w  = ALU_OP_PASS_A;
        state_d   = S_ALU_WB;
      end
      S_ALU_WB: begin
        regfile_write_enable = 1'b1;
        mem_to_reg           = MEM_TO_REG_ALU_OUT;
        state_d              = S_IF;
      end
      S_LR_ADDR, S_SR_ADDR: begin
        alu_src_a = ALU_SRC_A_REG;
        alu_src_b = ALU_SRC_B_IMM_BYTES;
        state_d   = (state_q == S_LR_ADDR) ? S_MEM_READ : S_MEM_STORE;
      end
      S_MEM_READ: begin
        mem_read   = 1'b1;
        mem_select = 1'b1;
        if (mem_ready)      state_d = S_MEM_WB;
        else if (timeout_w) state_d = S_ERROR;
      end
      S_MEM_WB: begin
        mem_select           = 1'b1;
        regfile_write_enable = 1'b1;
        mem_to_reg           = MEM_TO_REG_MEMORY;
        state_d              = S_IF;
      end
      S_MEM_STORE: begin
        mem_select = 1'b1;
        if (mem_ready)      state_d = S_IF;
        else if (timeout_w) state_d = S_ERROR;
      end
      S_BRANCH: begin
        alu_src_a = ALU_SRC_A_REG;
        alu_src_b = ALU_SRC_B_REG;
        alu_op_w  = ALU_OP_SUB;
        if (((op_held_w == INSTR_BNEQ) && !zero) ||
            ((op_held_w == INSTR_BEQ)  &&  zero)) begin
          pc_source       = PC_SELECT_ALU_BUF;
          pc_write_enable = 1'b1;
        end
        state_d = S_IF;
      end
      S_JUMP: begin
        pc_source       = PC_SELECT_ALU_BUF;
        pc_write_enable = 1'b1;
        state_d         = S_IF;
      end
      S_ERROR: begin
        error   = 1'b1;
        state_d = S_ERROR;
      end
      default: begin
        state_d = S_ERROR;
      end
    endcase
  end

  assign alu_op = ALU_OP_NUM_BITS'(alu_op_w);
  assign state  = state_q;

endmodule : multicycle_ctrl
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multicycle_ctrl
//  Purpose  : Self-checking bench for multicycle_ctrl. Stimulus pushes the
//             hand-computed state/output vector for each cycle into a queue;
//             an independent monitor pops and compares on the falling edge.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_ctrl;
  import multicycle_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instruction = '0;
  logic        zero = 1'b0;
  logic        mem_ready = 1'b0;

  logic       ireg_write_enable, regfile_write_enable, pc_write_enable;
  logic       mem_read, mem_select, mem_to_reg, alu_src_a, error;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] dut_state;

  multicycle_ctrl #(
    .INSTRUCTION_WIDTH (16),
    .WIDTH_OPCODE      (4),
    .ALU_OP_NUM_BITS   (3),
    .MEM_TIMEOUT       (4)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .instruction          (instruction),
    .zero                 (zero),
    .mem_ready            (mem_ready),
    .ireg_write_enable    (ireg_write_enable),
    .regfile_write_enable (regfile_write_enable),
    .pc_write_enable      (pc_write_enable),
    .mem_read             (mem_read),
    .mem_select           (mem_select),
    .mem_to_reg           (mem_to_reg),
    .alu_src_a            (alu_src_a),
    .alu_src_b            (alu_src_b),
    .alu_op               (alu_op),
    .pc_source            (pc_source),
    .error                (error),
    .state                (dut_state)
  );

  initial forever #5 clk = ~clk;

  // Output vector field order:
  // {ireg_we, rf_we, pc_we, mem_read, mem_select, mem_to_reg, alu_src_a}, alu_src_b, alu_op, pc_source, error
  logic [14:0] act_outs;
  assign act_outs = {ireg_write_enable, regfile_write_enable, pc_write_enable, mem_read,
                     mem_select, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source, error};

  localparam logic [14:0] O_RESET    = {7'b0011000, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [14:0] O_IF_RDY   = {7'b1011000, 2'd1, 3'd0, 2'd1, 1'b0};
  localparam logic [14:0] O_IF_WAIT  = {7'b0001000, 2'd1, 3'd0, 2'd1, 1'b0};
  localparam logic [14:0] O_ID       = {7'b0000000, 2'd3, 3'd0, 2'd0, 1'b0};
  localparam logic [14:0] O_EXEC_ADD = {7'b0000001, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [14:0] O_EXEC_SUB = {7'b0000001, 2'd0, 3'd1, 2'd0, 1'b0};
  localparam logic [14:0] O_EXEC_AND = {7'b0000001, 2'd0, 3'd2, 2'd0, 1'b0};
  localparam logic [14:0] O_EXEC_OR  = {7'b0000001, 2'd0, 3'd3, 2'd0, 1'b0};
  localparam logic [14:0] O_ALU_WB   = {7'b0100000, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [14:0] O_ADDR     = {7'b0000001, 2'd2, 3'd0, 2'd0, 1'b0};
  localparam logic [14:0] O_MOVE     = {7'b0000001, 2'd0, 3'd4, 2'd0, 1'b0};
  localparam logic [14:0] O_MEM_RD   = {7'b0001100, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [14:0] O_MEM_WB   = {7'b0100110, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [14:0] O_MEM_ST   = {7'b0000100, 2'd0, 3'd0, 2'd0, 1'b0};
  localparam logic [14:0] O_BR_TAKEN = {7'b0010001, 2'd0, 3'd1, 2'd2, 1'b0};
  localparam logic [14:0] O_BR_NOT   = {7'b0000001, 2'd0, 3'd1, 2'd0, 1'b0};
  localparam logic [14:0] O_JUMP     = {7'b0010000, 2'd0, 3'd0, 2'd2, 1'b0};
  localparam logic [14:0] O_ERROR    = {7'b0000000, 2'd0, 3'd0, 2'd0, 1'b1};

  typedef struct {
    logic [3:0]  st;
    logic [14:0] outs;
    string       tag;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Monitor: compares the DUT against the oldest queued expectation.
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_checks++;
      if (dut_state === e.st) n_pass++;
      else $display("FAIL %s state: got %0d expected %0d", e.tag, dut_state, e.st);
      n_checks++;
      if (act_outs === e.outs) n_pass++;
      else $display("FAIL %s outputs: got %b expected %b", e.tag, act_outs, e.outs);
    end
  end

  // One clock cycle: apply inputs, queue the expected state/outputs for this
  // cycle, then advance past the next rising edge.
  task automatic cyc(input logic rst, input logic [3:0] op, input logic z, input logic mr,
                     input logic [3:0] est, input logic [14:0] eo, input string tag);
    reset       = rst;
    instruction = {op, 12'h5A3};
    zero        = z;
    mem_ready   = mr;
    exp_q.push_back('{est, eo, tag});
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_decode(input logic [3:0] op, input string tag);
    cyc(1'b0, op, 1'b0, 1'b1, 4'd1, O_IF_RDY, {tag, "_if"});
    cyc(1'b0, op, 1'b0, 1'b0, 4'd3, O_ID,     {tag, "_id"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, INSTR_NOP, 1'b0, 1'b0, 4'd0, O_RESET, "reset_hold");
    cyc(1'b0, INSTR_ADD, 1'b0, 1'b1, 4'd0, O_RESET, "reset_exit");

    // ADD; instruction changes while in EXEC must not affect alu_op
    fetch_decode(INSTR_ADD, "add");
    cyc(1'b0, INSTR_SUB, 1'b0, 1'b1, 4'd6,  O_EXEC_ADD, "add_exec");
    cyc(1'b0, INSTR_SUB, 1'b0, 1'b1, 4'd14, O_ALU_WB,   "add_wb");

    // SUB after two fetch wait cycles
    cyc(1'b0, INSTR_SUB, 1'b0, 1'b0, 4'd1, O_IF_WAIT, "sub_if_wait0");
    cyc(1'b0, INSTR_SUB, 1'b0, 1'b0, 4'd1, O_IF_WAIT, "sub_if_wait1");
    fetch_decode(INSTR_SUB, "sub");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd6,  O_EXEC_SUB, "sub_exec");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd14, O_ALU_WB,   "sub_wb");

    fetch_decode(INSTR_AND, "and");
    cyc(1'b0, INSTR_AND, 1'b0, 1'b0, 4'd6,  O_EXEC_AND, "and_exec");
    cyc(1'b0, INSTR_AND, 1'b0, 1'b0, 4'd14, O_ALU_WB,   "and_wb");
    fetch_decode(INSTR_OR, "or");
    cyc(1'b0, INSTR_OR, 1'b0, 1'b0, 4'd6,  O_EXEC_OR, "or_exec");
    cyc(1'b0, INSTR_OR, 1'b0, 1'b0, 4'd14, O_ALU_WB,  "or_wb");

    // LR: three MEM_READ waits, then ready on the cycle the timeout would fire
    fetch_decode(INSTR_LR, "lr");
    cyc(1'b0, INSTR_LR, 1'b0, 1'b0, 4'd4, O_ADDR, "lr_addr");
    for (int i = 0; i < 3; i++)
      cyc(1'b0, INSTR_LR, 1'b0, 1'b0, 4'd11, O_MEM_RD, "lr_mem_wait");
    cyc(1'b0, INSTR_LR, 1'b0, 1'b1, 4'd11, O_MEM_RD, "lr_mem_ready");
    cyc(1'b0, INSTR_LR, 1'b0, 1'b0, 4'd12, O_MEM_WB, "lr_wb");

    // SR completing immediately
    fetch_decode(INSTR_SR, "sr");
    cyc(1'b0, INSTR_SR, 1'b0, 1'b0, 4'd5,  O_ADDR,   "sr_addr");
    cyc(1'b0, INSTR_SR, 1'b0, 1'b1, 4'd13, O_MEM_ST, "sr_store");

    // Branches
    fetch_decode(INSTR_BEQ, "beq_z1");
    cyc(1'b0, INSTR_NOP, 1'b1, 1'b0, 4'd7, O_BR_TAKEN, "beq_z1_br");
    fetch_decode(INSTR_BNEQ, "bneq_z1");
    cyc(1'b0, INSTR_NOP, 1'b1, 1'b0, 4'd7, O_BR_NOT, "bneq_z1_br");
    fetch_decode(INSTR_BNEQ, "bneq_z0");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd7, O_BR_TAKEN, "bneq_z0_br");
    fetch_decode(INSTR_BEQ, "beq_z0");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd7, O_BR_NOT, "beq_z0_br");

    fetch_decode(INSTR_JMP, "jmp");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd10, O_JUMP, "jmp_exec");

    fetch_decode(INSTR_MOV, "mov");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd8,  O_MOVE,   "mov_exec");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd14, O_ALU_WB, "mov_wb");
    fetch_decode(INSTR_LI, "li");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd9,  O_ADDR,   "li_exec");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd14, O_ALU_WB, "li_wb");
    fetch_decode(INSTR_ADDI, "addi");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd9,  O_ADDR,   "addi_exec");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd14, O_ALU_WB, "addi_wb");

    // NOP goes straight back to fetch
    fetch_decode(INSTR_NOP, "nop");

    // Reset in the middle of a store wait
    fetch_decode(INSTR_SR, "sr_rst");
    cyc(1'b0, INSTR_SR, 1'b0, 1'b0, 4'd5,  O_ADDR,   "sr_rst_addr");
    cyc(1'b0, INSTR_SR, 1'b0, 1'b0, 4'd13, O_MEM_ST, "sr_rst_wait0");
    cyc(1'b0, INSTR_SR, 1'b0, 1'b0, 4'd13, O_MEM_ST, "sr_rst_wait1");
    cyc(1'b1, INSTR_SR, 1'b0, 1'b0, 4'd13, O_MEM_ST, "sr_rst_assert");
    cyc(1'b0, INSTR_SR, 1'b0, 1'b0, 4'd0,  O_RESET,  "sr_rst_state");
    // Three waits plus ready: a stale counter would have timed out here
    for (int i = 0; i < 3; i++)
      cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd1, O_IF_WAIT, "post_rst_if_wait");
    fetch_decode(INSTR_NOP, "post_rst");

    // Fetch timeout: four IF wait cycles, then sticky ERROR
    for (int i = 0; i < 4; i++)
      cyc(1'b0, INSTR_NOP, 1'b0, 1'b0, 4'd1, O_IF_WAIT, "if_timeout_wait");
    for (int i = 0; i < 20; i++)
      cyc(1'b0, INSTR_ADD, 1'(i), 1'(i), 4'd15, O_ERROR, "error_sticky");
    cyc(1'b1, INSTR_NOP, 1'b0, 1'b0, 4'd15, O_ERROR, "error_rst_assert");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b1, 4'd0,  O_RESET, "error_rst_state");

    // Undefined opcode
    fetch_decode(4'hF, "undef");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b1, 4'd15, O_ERROR, "undef_error");

    // Load timeout in MEM_READ
    cyc(1'b1, INSTR_NOP, 1'b0, 1'b0, 4'd15, O_ERROR, "undef_rst_assert");
    cyc(1'b0, INSTR_NOP, 1'b0, 1'b1, 4'd0,  O_RESET, "undef_rst_state");
    fetch_decode(INSTR_LR, "lr_to");
    cyc(1'b0, INSTR_LR, 1'b0, 1'b0, 4'd4, O_ADDR, "lr_to_addr");
    for (int i = 0; i < 4; i++)
      cyc(1'b0, INSTR_LR, 1'b0, 1'b0, 4'd11, O_MEM_RD, "lr_to_wait");
    cyc(1'b0, INSTR_LR, 1'b0, 1'b1, 4'd15, O_ERROR, "lr_to_error");

    // Let the monitor drain the queue, bounded
    for (int i = 0; i < 10; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: %0d entries left, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_multicycle_ctrl
`default_nettype wire

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter INSTRUCTION_WIDTH, default 16: instruction word width.
REQ-002 Parameter WIDTH_OPCODE, default 4: opcode field width, taken from instruction MSBs.
REQ-003 Parameter ALU_OP_NUM_BITS, default 3: alu_op width.
REQ-004 Parameter MEM_TIMEOUT, default 15, range 1..255: maximum mem_ready wait cycles before error.
REQ-005 clk  in  1  clock; all state changes occur on rising edge.
REQ-006 reset  in  1  reset, synchronous, active-high.
REQ-007 instruction  in  INSTRUCTION_WIDTH  instruction register contents.
REQ-008 zero  in  1  ALU zero flag.
REQ-009 mem_ready  in  1  memory access completes this cycle.
REQ-010 ireg_write_enable, regfile_write_enable, pc_write_enable, mem_read, mem_select, mem_to_reg  out  1 each  datapath strobes/selects.
REQ-011 alu_src_a  out  1  0=PC, 1=register A.
REQ-012 alu_src_b  out  2  0=register B, 1=+2, 2=imm bytes, 3=imm word.
REQ-013 alu_op  out  ALU_OP_NUM_BITS  ALU function.
REQ-014 pc_source  out  2  PC mux select (PC_SELECT_* codes).
REQ-015 error  out  1  sticky fault flag.
REQ-016 state  out  4  current state encoding, for debug.

Function
REQ-017 States: RESET=0, IF=1, ID=3, LR_ADDR=4, SR_ADDR=5, EXEC=6, BRANCH=7, MOVE=8, ADDI=9, JUMP=10, MEM_READ=11, MEM_WB=12, MEM_STORE=13, ALU_WB=14, ERROR=15.
REQ-018 Default for all outputs: 0, alu_op=ALU_OP_ADD, pc_source=PC_SELECT_RESET, mem_to_reg=ALU_OUT.
REQ-019 RESET: pc_write_enable=1, mem_read=1; next IF.
REQ-020 IF: mem_read=1, alu_src_b=+2, pc_source=PC_SELECT_ALU; pc_write_enable and ireg_write_enable asserted only when mem_ready=1; stays in IF while mem_ready=0; next ID on mem_ready=1.
REQ-021 ID: opcode latched into internal register op_q; alu_src_a=PC, alu_src_b=imm word, ADD (branch target precomputed); dispatch NOP->IF, ADD/SUB/AND/OR->EXEC, LR->LR_ADDR, SR->SR_ADDR, BNEQ/BEQ->BRANCH, MOV->MOVE, LI/ADDI->ADDI, JMP->JUMP, other->ERROR.
REQ-022 EXEC: src A=reg, B=reg; alu_op from op_q (ADD/SUB/AND/OR); next ALU_WB.
REQ-023 ADDI: src A=reg, B=imm bytes, ADD; next ALU_WB. MOVE: src A=reg, B=reg, alu_op=ALU_OP_PASS_A; next ALU_WB.
REQ-024 ALU_WB: regfile_write_enable=1, mem_to_reg=ALU_OUT; next IF.
REQ-025 LR_ADDR/SR_ADDR: src A=reg, B=imm bytes, ADD; next MEM_READ / MEM_STORE.
REQ-026 MEM_READ: mem_read=1, mem_select=1; hold until mem_ready=1, then MEM_WB. MEM_WB: mem_select=1, regfile_write_enable=1, mem_to_reg=MEMORY; next IF.
REQ-027 MEM_STORE: mem_select=1, mem_read=0; hold until mem_ready=1, then IF.
REQ-028 BRANCH: SUB reg/reg; take when (BNEQ and zero=0) or (BEQ and zero=1): pc_source=PC_SELECT_ALU_BUF, pc_write_enable=1; else pc_write_enable=0; next IF.
REQ-029 JUMP: pc_source=PC_SELECT_ALU_BUF, pc_write_enable=1; next IF.
REQ-030 Wait counter: 8-bit, cleared on entering IF/MEM_READ/MEM_STORE and on mem_ready=1; increments each wait cycle; mem_ready=0 when counter equals MEM_TIMEOUT-1 -> ERROR next cycle.
REQ-031 ERROR: all enables 0, error=1; remains in ERROR until reset.
REQ-032 mem_ready=1 on the cycle a timeout would fire: completion wins.
REQ-033 mem_ready ignored outside IF, MEM_READ, MEM_STORE.
REQ-034 Outputs combinational from state, op_q, zero, mem_ready; no latches.

Reset
REQ-035 reset=1 on any edge, including mid-wait: state=RESET, op_q=0, counter=0, error=0; overrides all transitions.
REQ-036 Output values while in RESET per REQ-019.

Structure
REQ-037 INSTR_* opcodes, ALU_OP_* (ADD, SUB, AND, OR, PASS_A), PC_SELECT_* and state encodings live in shared params.v.
REQ-038 Sub-module mem_wait_timer (counter + timeout compare) instantiated once.

Verification
REQ-039 reset 2 cycles, mem_ready=1 constant, ADD -> states 0,1,3,6,14,1; regfile_write_enable high exactly in state 14.
REQ-040 LR with mem_ready low 3 cycles in MEM_READ -> 3 extra MEM_READ cycles, then MEM_WB with mem_to_reg=1.
REQ-041 BEQ zero=1 -> pc_write_enable=1, pc_source=ALU_BUF; BNEQ zero=1 -> pc_write_enable=0.
REQ-042 MEM_TIMEOUT=4, mem_ready=0 in IF -> ERROR after 4 IF cycles; error stays 1 for 20 cycles; reset clears.
REQ-043 Undefined opcode 4'hF -> ID then ERROR; instruction change during EXEC does not alter alu_op.
REQ-044 reset asserted in MEM_STORE wait -> next state RESET, counter 0, no regfile write.
